sm_add_sched: RTL and testbench

SM_ADD_SCHED -- requirements
Module: sm_add_sched

---
 rtl/sm_add_sched.sv | 133 +++++++++++++
 tb/tb_sm_add_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_add_sched.sv
// Two-requester sign-magnitude adder with a round-robin arbiter and one shared adder.
// An accepted operation is computed in EXEC and held in RESP until the consumer takes it.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept at most one operation
// EXEC  | compute the sum of the latched operands, register the response
// RESP  | hold the response until rsp_ready, then return to IDLE
module sm_add_sched #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [n-1:0] req0_opA,
    input  logic [n-1:0] req0_opB,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [n-1:0] req1_opA,
    input  logic [n-1:0] req1_opB,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_res,
    output logic         rsp_ovf,
    output logic         rsp_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic         ptr;
    logic [n-1:0] op_a;
    logic [n-1:0] op_b;
    logic         op_id;

    logic         gnt_any;
    logic         gnt_id;

    // ptr names the requester that wins when both are valid
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = ptr;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;

    logic [n-2:0] mag_a;
    logic [n-2:0] mag_b;
    logic [n-2:0] mag_r;
    logic         sgn_a;
    logic         sgn_b;
    logic         sgn_r;
    logic         ovf_r;
    logic [n-1:0] sum;

    // A zero magnitude always counts as positive, on input and on output
    always_comb begin
        mag_a = op_a[n-2:0];
        mag_b = op_b[n-2:0];
        sgn_a = op_a[n-1] && (mag_a != '0);
        sgn_b = op_b[n-1] && (mag_b != '0);
        sum   = '0;
        mag_r = '0;
        sgn_r = 1'b0;
        ovf_r = 1'b0;
        if (sgn_a == sgn_b) begin
            sum   = {1'b0, mag_a} + {1'b0, mag_b};
            mag_r = sum[n-2:0];
            ovf_r = sum[n-1];
            sgn_r = sgn_a;
        end else if (mag_a >= mag_b) begin
            mag_r = mag_a - mag_b;
            sgn_r = sgn_a;
        end else begin
            mag_r = mag_b - mag_a;
            sgn_r = sgn_b;
        end
        if (mag_r == '0)
            sgn_r = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a  <= gnt_id ? req1_opA : req0_opA;
                        op_b  <= gnt_id ? req1_opB : req0_opB;
                        op_id <= gnt_id;
                        ptr   <= !gnt_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res   <= {sgn_r, mag_r};
                    rsp_ovf   <= ovf_r;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_add_sched.sv
// Self-checking bench for sm_add_sched: directed scenarios plus a randomized run
// against an integer-arithmetic reference model.
module tb_sm_add_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_opA, req0_opB, req1_opA, req1_opB;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready;
    logic [N-1:0] rsp_res;
    logic         rsp_ovf, rsp_id;

    int errors = 0;
    int checks = 0;

    sm_add_sched #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: true signed sum, then wrap the magnitude if it does not fit. Returns {ovf, res}.
    function automatic logic [N:0] model_add(logic [N-1:0] a, logic [N-1:0] b);
        int va, vb, t, mag, lim;
        logic [N-1:0] r;
        logic o;
        lim = 1 << (N - 1);
        va = int'(a[N-2:0]);
        if (a[N-1]) va = -va;
        vb = int'(b[N-2:0]);
        if (b[N-1]) vb = -vb;
        t = va + vb;
        mag = (t < 0) ? -t : t;
        o = 1'b0;
        if (mag >= lim) begin
            mag = mag % lim;
            o = 1'b1;
        end
        r = N'(mag);
        r[N-1] = (t < 0) && (mag != 0);
        return {o, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_opA = 4'b0101; req0_opB = 4'b0011;
        req1_opA = 4'b0001; req1_opB = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp_valid, rsp_ovf, rsp_id, rsp_res} !== 7'b0) begin
            errors++; $display("FAIL reset_rsp: got %b expected 0000000", {rsp_valid, rsp_ovf, rsp_id, rsp_res});
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        req0_valid = 1'b1; req0_opA = 4'b1111; req0_opB = 4'b0110;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL basic_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b expected 0", rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_ovf, rsp_id, rsp_res} !== {1'b1, 1'b0, 1'b0, 4'b1001}) begin
            errors++; $display("FAIL basic_rsp: got v=%b o=%b id=%b res=%b expected v=1 o=0 id=0 res=1001",
                               rsp_valid, rsp_ovf, rsp_id, rsp_res);
        end
        step();
    endtask

    task automatic test_corners();
        logic [N-1:0] ta[5];
        logic [N-1:0] tb[5];
        logic [N:0]   te[5];
        ta = '{4'b0101, 4'b0100, 4'b1000, 4'b0111, 4'b1111};
        tb = '{4'b0011, 4'b1100, 4'b1000, 4'b0111, 4'b1001};
        te = '{5'b1_0000, 5'b0_0000, 5'b0_0000, 5'b1_0110, 5'b1_0000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req0_opA = ta[i]; req0_opB = tb[i];
            step();
            req0_valid = 1'b0;
            step();
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_ovf, rsp_res} !== {1'b1, te[i]}) begin
                errors++; $display("FAIL corner_%0d: %b+%b got v=%b o=%b res=%b expected v=1 o=%b res=%b",
                                   i, ta[i], tb[i], rsp_valid, rsp_ovf, rsp_res, te[i][N], te[i][N-1:0]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [N:0] exp;
        req1_opA = 4'($urandom); req1_opB = 4'($urandom);
        exp = model_add(req1_opA, req1_opB);
        req1_valid = 1'b1; req0_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_ovf, rsp_id, rsp_res, req0_ready, req1_ready} !== {1'b1, exp[N], 1'b1, exp[N-1:0], 2'b00}) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b o=%b id=%b res=%b rdy=%b%b expected v=1 o=%b id=1 res=%b rdy=00",
                                   i, rsp_valid, rsp_ovf, rsp_id, rsp_res, req0_ready, req1_ready, exp[N], exp[N-1:0]);
            end
            step();
        end
        rsp_ready = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
            errors++; $display("FAIL bp_release: got v=%b rdy=%b%b expected v=1 rdy=00", rsp_valid, req0_ready, req1_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_next_grant: got v=%b rdy=%b%b expected v=0 rdy=01", rsp_valid, req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
            errors++; $display("FAIL withdraw_no_grant: got v=%b rdy=%b%b expected v=0 rdy=10", rsp_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [N:0] exp;
        logic       eid;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eid = k[0];
            req0_opA = 4'($urandom); req0_opB = 4'($urandom);
            req1_opA = 4'($urandom); req1_opB = 4'($urandom);
            exp = eid ? model_add(req1_opA, req1_opB) : model_add(req0_opA, req0_opB);
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== {!eid, eid}) begin
                errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, {req0_ready, req1_ready}, {!eid, eid});
            end
            step();
            @(negedge clk);
            checks++;
            if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
                errors++; $display("FAIL rr_exec_%0d: got v=%b rdy=%b%b expected all 0", k, rsp_valid, req0_ready, req1_ready);
            end
            step();
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_ovf, rsp_res} !== {1'b1, eid, exp}) begin
                errors++; $display("FAIL rr_rsp_%0d: got v=%b id=%b o=%b res=%b expected v=1 id=%b o=%b res=%b",
                                   k, rsp_valid, rsp_id, rsp_ovf, rsp_res, eid, exp[N], exp[N-1:0]);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        do_reset();
        req0_valid = 1'b1; req0_opA = 4'b0011; req0_opB = 4'b0010;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
                errors++; $display("FAIL abort_%0d: got v=%b rdy=%b%b expected all 0", i, rsp_valid, req0_ready, req1_ready);
            end
            step();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
            errors++; $display("FAIL abort_first_grant: got v=%b rdy=%b%b expected v=0 rdy=10", rsp_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int         phase;
        logic       mptr, e_any, e_id, eid;
        logic [N:0] exp;
        do_reset();
        phase = 0; mptr = 1'b0; eid = 1'b0; exp = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_opA = 4'($urandom); req0_opB = 4'($urandom);
            req1_opA = 4'($urandom); req1_opB = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_any = (phase == 0) && (req0_valid || req1_valid);
            e_id = (req0_valid && req1_valid) ? mptr : req1_valid;
            checks++;
            if ({req0_ready, req1_ready} !== {e_any && !e_id, e_any && e_id}) begin
                errors++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, {req0_ready, req1_ready},
                                   {e_any && !e_id, e_any && e_id});
            end
            checks++;
            if (rsp_valid !== (phase == 2)) begin
                errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, rsp_valid, phase == 2);
            end
            if (phase == 2) begin
                checks++;
                if ({rsp_id, rsp_ovf, rsp_res} !== {eid, exp}) begin
                    errors++; $display("FAIL rand_rsp c=%0d: got id=%b o=%b res=%b expected id=%b o=%b res=%b",
                                       c, rsp_id, rsp_ovf, rsp_res, eid, exp[N], exp[N-1:0]);
                end
            end
            if (e_any) begin
                exp = e_id ? model_add(req1_opA, req1_opB) : model_add(req0_opA, req0_opB);
                eid = e_id;
                mptr = !e_id;
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2 && rsp_ready) begin
                phase = 0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opA = '0; req0_opB = '0; req1_opA = '0; req1_opB = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_round_robin();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
